// File: rtl/dma_arbiter_if.sv
// Bundle between the two DMA requesters, the arbiter and the shared DMA port.
// The arbiter uses the slave modport; the requester/DMA side uses the master modport.
interface dma_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  logic                  req0;
  logic                  rw0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1;
  logic                  rw1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic                  dma_enable;
  logic                  dma_rw;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  busy;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    output gnt0, gnt1, done0, done1, dma_enable, dma_rw, dma_addr, dma_wdata, busy
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    input  gnt0, gnt1, done0, done1, dma_enable, dma_rw, dma_addr, dma_wdata, busy
  );
endinterface

// File: rtl/dma_arbiter.sv
// Two-requester arbiter/sequencer for the shared CNN DMA port (round-robin ties).
// Define DMA_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no last-served pointer).
module dma_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 20,
  parameter int DMA_LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  dma_arbiter_if.slave  bus
);

  localparam int CW = (DMA_LATENCY > 1) ? $clog2(DMA_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  winner;

`ifdef DMA_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~bus.req0;
  end
`else
  logic last_q, last_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (bus.req0 && bus.req1) winner = ~last_q;
    else                      winner = ~bus.req0;
  end
`endif

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifndef DMA_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ISSUE;
          owner_d = winner;
`ifndef DMA_ARB_FIXED_PRIO_EN
          last_d  = winner;
`endif
          rw_d    = winner ? bus.rw1    : bus.rw0;
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(DMA_LATENCY - 1);
        state_d = (DMA_LATENCY == 1) ? DONE : WAIT;
      end
      // The counter reaches zero as the FSM enters DONE, DMA_LATENCY cycles after the strobe.
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        rw_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifndef DMA_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifndef DMA_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.gnt0       = (state_q != IDLE) && !owner_q;
  assign bus.gnt1       = (state_q != IDLE) &&  owner_q;
  assign bus.done0      = (state_q == DONE) && !owner_q;
  assign bus.done1      = (state_q == DONE) &&  owner_q;
  assign bus.dma_enable = (state_q == ISSUE);
  assign bus.dma_rw     = rw_q;
  assign bus.dma_addr   = addr_q;
  assign bus.dma_wdata  = wdata_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: a DMA_LATENCY=4 instance and a DMA_LATENCY=1 instance.
// Expected transactions are queued when requests are driven and retired on each dma_enable.
module tb_dma_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 20;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
  dma_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  dma_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DMA_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dma_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DMA_LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          owner;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            en_cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   trk   = 1'b0;
  int   trk_k = 0;

  function automatic logic tie_owner(input int i);
`ifdef DMA_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return logic'(i % 2);
`endif
  endfunction

  // Main-instance monitor: retires one queued transaction per strobe and follows it to idle.
  always @(negedge clk) begin
    if (reset) begin
      trk = 1'b0;
    end else begin
      if (trk) begin
        trk_k++;
        if (trk_k <= LAT) begin
          check("gnt_owner_held", cur.owner ? bus.gnt1 : bus.gnt0, 1);
          check("gnt_other_low",  cur.owner ? bus.gnt0 : bus.gnt1, 0);
          check("enable_one_cycle", bus.dma_enable, 0);
          check("addr_held",  bus.dma_addr,  cur.addr);
          check("rw_held",    bus.dma_rw,    cur.rw);
          check("wdata_held", bus.dma_wdata, cur.wdata);
          check("done_owner", cur.owner ? bus.done1 : bus.done0, (trk_k == LAT));
          check("done_other", cur.owner ? bus.done0 : bus.done1, 0);
        end else begin
          check("idle_busy", bus.busy, 0);
          check("idle_gnt",  {bus.gnt0, bus.gnt1}, 0);
          check("idle_bus",  {bus.dma_rw, bus.dma_addr, bus.dma_wdata}, 0);
          trk = 1'b0;
        end
      end else begin
        check("stray_done", {bus.done0, bus.done1}, 0);
      end
      if (bus.dma_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          cur   = exp_q.pop_front();
          trk   = 1'b1;
          trk_k = 0;
          check("strobe_cycle", cyc, cur.en_cyc);
          check("issue_gnt",    {bus.gnt1, bus.gnt0}, cur.owner ? 2'b10 : 2'b01);
          check("issue_busy",   bus.busy, 1);
          check("issue_addr",   bus.dma_addr,  cur.addr);
          check("issue_rw",     bus.dma_rw,    cur.rw);
          check("issue_wdata",  bus.dma_wdata, cur.wdata);
        end
      end
    end
  end

  // DMA_LATENCY=1 instance: done right after the strobe, strobes 3 cycles apart under load.
  logic exp1_q[$];
  logic own1;
  bit   trk1    = 1'b0;
  int   k1      = 0;
  int   last_en1 = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (trk1) begin
        k1++;
        if (k1 == 1) begin
          check("l1_done", own1 ? bus1.done1 : bus1.done0, 1);
          check("l1_enable_one_cycle", bus1.dma_enable, 0);
        end else begin
          check("l1_idle_busy", bus1.busy, 0);
          trk1 = 1'b0;
        end
      end
      if (bus1.dma_enable) begin
        if (exp1_q.size() == 0) begin
          check("l1_unexpected_strobe", 1, 0);
        end else begin
          own1 = exp1_q.pop_front();
          check("l1_gnt", {bus1.gnt1, bus1.gnt0}, own1 ? 2'b10 : 2'b01);
          if (last_en1 >= 0) check("l1_strobe_spacing", cyc - last_en1, 3);
          last_en1 = cyc;
          trk1 = 1'b1;
          k1   = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    {bus.req0, bus.rw0, bus.addr0, bus.wdata0}     = '0;
    {bus.req1, bus.rw1, bus.addr1, bus.wdata1}     = '0;
    {bus1.req0, bus1.rw0, bus1.addr0, bus1.wdata0} = '0;
    {bus1.req1, bus1.rw1, bus1.addr1, bus1.wdata1} = '0;

    // Reset with a request pending: reset must win.
    reset    = 1'b1;
    bus.req0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",    {bus.gnt0, bus.gnt1}, 0);
    check("rst_busy",   bus.busy, 0);
    check("rst_enable", bus.dma_enable, 0);
    check("rst_done",   {bus.done0, bus.done1}, 0);
    check("rst_bus",    {bus.dma_rw, bus.dma_addr, bus.dma_wdata}, 0);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Single read request from requester 1.
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 20'h00012; bus.wdata1 = 16'h5A5A;
    exp_q.push_back('{owner: 1'b1, rw: 1'b1, addr: 20'h00012, wdata: 16'h5A5A, en_cyc: cyc + 1});
    tick(1);
    bus.req1 = 1'b0;
    tick(LAT + 2);

    // Write from requester 0, request and data dropped right after the grant.
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 20'h00100; bus.wdata0 = 16'hBEEF;
    exp_q.push_back('{owner: 1'b0, rw: 1'b0, addr: 20'h00100, wdata: 16'hBEEF, en_cyc: cyc + 1});
    tick(1);
    bus.req0 = 1'b0; bus.wdata0 = 16'h1234; bus.addr0 = 20'h0FFFF;
    tick(LAT + 2);

    // Held tie after reset.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus.rw0 = 1'b1; bus.addr0 = 20'h000A0; bus.wdata0 = 16'h00A0;
    bus.rw1 = 1'b0; bus.addr1 = 20'h000B0; bus.wdata1 = 16'h00B0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic o;
      o = tie_owner(i);
      exp_q.push_back('{owner: o, rw: o ? 1'b0 : 1'b1, addr: o ? 20'h000B0 : 20'h000A0,
                        wdata: o ? 16'h00B0 : 16'h00A0, en_cyc: cyc + 1 + i * (LAT + 2)});
    end
    tick(1 + 3 * (LAT + 2));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(LAT + 2);

    // Reset two cycles after the strobe drops the transaction; the next tie goes to 0.
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 20'h00300; bus.wdata0 = 16'h0300;
    exp_q.push_back('{owner: 1'b0, rw: 1'b1, addr: 20'h00300, wdata: 16'h0300, en_cyc: cyc + 1});
    tick(1);
    bus.req0 = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_gnt",  {bus.gnt0, bus.gnt1}, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", {bus.done0, bus.done1}, 0);
    check("abort_bus",  {bus.dma_enable, bus.dma_rw, bus.dma_addr, bus.dma_wdata}, 0);
    tick(LAT + 1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    exp_q.push_back('{owner: 1'b0, rw: 1'b1, addr: 20'h00300, wdata: 16'h0300, en_cyc: cyc + 1});
    tick(1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(LAT + 2);

    // Minimum latency: held tie on the DMA_LATENCY=1 instance.
    bus1.req0 = 1'b1; bus1.req1 = 1'b1;
    for (int i = 0; i < 4; i++) exp1_q.push_back(tie_owner(i));
    tick(1 + 3 * 3);
    bus1.req0 = 1'b0; bus1.req1 = 1'b0;
    tick(4);

    check("sb_drained",    exp_q.size(),  0);
    check("l1_sb_drained", exp1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
